// File: rtl/sort_pkg.sv
// ============================================================================
//  Module   : sort_pkg
//  Purpose  : Shared types and sizing helpers for the sort result streamer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_pkg;

    // Default word width of the sort engine result vector
    localparam int c_WORD_W_DEFAULT = 32;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KICK   = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } state_t;

    // Number of output beats needed to carry one full result vector
    function automatic int num_beats(input int total_num, input int word_w, input int beat_w);
        return (total_num * word_w) / beat_w;
    endfunction

    // Width of a counter indexing n items; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_beat_sel.sv
// ============================================================================
//  Module   : sort_beat_sel
//  Purpose  : Combinational selector returning beat i_idx of a wide vector,
//             beat 0 being the least significant slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_beat_sel
    import sort_pkg::*;
#(
    parameter int VEC_W     = 512,
    parameter int BEAT_W    = 128,
    parameter int NUM_BEATS = 4,
    parameter int IDX_W     = cnt_width(NUM_BEATS)
) (
    input  logic [VEC_W-1:0]  i_vec,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [BEAT_W-1:0] o_beat
);

    // Mux the requested beat; out-of-range indices return zero
    always_comb begin
        o_beat = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_beat = i_vec[k*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sort_stream_out.sv
// ============================================================================
//  Module   : sort_stream_out
//  Purpose  : Kicks the sort engine, waits for completion and streams the
//             sorted result vector out as valid/ready beats with m_last.
//  Options  : SORT_STREAM_SHADOW_EN - capture the result into a shadow
//             register and allow the next job to be kicked while streaming.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_stream_out
    import sort_pkg::*;
#(
    parameter int TOTAL_NUM = 1024,
    parameter int WORD_W    = c_WORD_W_DEFAULT,
    parameter int BEAT_W    = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        job_done,
    output logic                        sort_start,
    input  logic                        sort_done,
    input  logic [TOTAL_NUM*WORD_W-1:0] sort_result,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [BEAT_W-1:0]           m_data,
    output logic                        m_last
);

    localparam int c_VEC_W     = TOTAL_NUM * WORD_W;
    localparam int c_NUM_BEATS = num_beats(TOTAL_NUM, WORD_W, BEAT_W);
    localparam int c_BCNT_W    = cnt_width(c_NUM_BEATS);
    localparam logic [c_BCNT_W-1:0] c_LAST_IDX = c_BCNT_W'(c_NUM_BEATS - 1);
    localparam logic c_ONE_BEAT = (c_NUM_BEATS == 1);

    // Reject geometries that cannot be split into whole beats
    generate
        if ((c_VEC_W % BEAT_W) != 0 || (TOTAL_NUM % 2) != 0 || TOTAL_NUM < 4) begin : g_param_check_fail
            $error("sort_stream_out: TOTAL_NUM must be even, >=4, and TOTAL_NUM*WORD_W a multiple of BEAT_W");
        end
    endgenerate

    state_t                r_state;
    logic [c_BCNT_W-1:0]   r_cnt;
    logic                  r_wait_arm;
    logic                  r_sort_start;
    logic                  r_job_done;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [BEAT_W-1:0]     r_m_data;

    logic                  w_hs;
    logic                  w_accept;
    logic                  w_pending;
    logic                  w_take_start;
    logic [c_BCNT_W-1:0]   w_next_cnt;
    logic [c_BCNT_W-1:0]   w_sel_idx;
    logic [c_VEC_W-1:0]    w_src;
    logic [BEAT_W-1:0]     w_beat;

    assign w_hs       = r_m_valid & m_ready;
    // First WAIT cycle is blind so a level left over from the last job is not taken
    assign w_accept   = (r_state == WAIT) & r_wait_arm & sort_done;
    assign w_next_cnt = r_cnt + 1'b1;
    // Beat 0 is loaded on acceptance; afterwards the next beat is prefetched
    assign w_sel_idx  = (r_state == STREAM) ? w_next_cnt : '0;

`ifdef SORT_STREAM_SHADOW_EN
    logic [c_VEC_W-1:0] r_shadow;
    logic               r_pending;

    // Beat 0 comes straight from the engine; the rest from the captured copy
    assign w_src        = (r_state == STREAM) ? r_shadow : sort_result;
    assign w_pending    = r_pending;
    assign w_take_start = start & (r_state == STREAM) & ~r_pending;

    // Capture the result so the engine is free to start the next job
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow <= sort_result;
        end
    end

    // Remember a job kicked during streaming until the current job ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_hs && r_m_last) begin
            r_pending <= 1'b0;
        end else if (w_take_start) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_src        = sort_result;
    assign w_pending    = 1'b0;
    assign w_take_start = 1'b0;
`endif

    sort_beat_sel #(
        .VEC_W     (c_VEC_W),
        .BEAT_W    (BEAT_W),
        .NUM_BEATS (c_NUM_BEATS),
        .IDX_W     (c_BCNT_W)
    ) u_beat_sel (
        .i_vec  (w_src),
        .i_idx  (w_sel_idx),
        .o_beat (w_beat)
    );

    // Job sequencing, beat counter and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_wait_arm   <= 1'b0;
            r_sort_start <= 1'b0;
            r_job_done   <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
        end else begin
            r_sort_start <= 1'b0;
            r_job_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sort_start <= 1'b1;
                        r_state      <= KICK;
                    end
                end
                KICK: begin
                    r_wait_arm <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (w_accept) begin
                        r_m_data  <= w_beat;
                        r_m_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_m_last  <= c_ONE_BEAT;
                        r_state   <= STREAM;
                    end else if (!r_wait_arm) begin
                        r_wait_arm <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_take_start) begin
                        r_sort_start <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_m_last) begin
                            r_m_valid  <= 1'b0;
                            r_m_last   <= 1'b0;
                            r_job_done <= 1'b1;
                            r_wait_arm <= 1'b0;
                            r_state    <= (w_pending | w_take_start) ? WAIT : IDLE;
                        end else begin
                            r_cnt    <= w_next_cnt;
                            r_m_data <= w_beat;
                            r_m_last <= (w_next_cnt == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign job_done   = r_job_done;
    assign sort_start = r_sort_start;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign m_data     = r_m_data;

endmodule

`default_nettype wire

// File: tb/tb_sort_stream_out.sv
// ============================================================================
//  Module   : tb_sort_stream_out
//  Purpose  : Directed self-checking bench for sort_stream_out with a small
//             behavioural sort engine (16 words x 32 bit, 128-bit beats).
//  Options  : SORT_STREAM_SHADOW_EN selects the streaming-restart scenario.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sort_stream_out;

    localparam int c_N      = 16;
    localparam int c_W      = 32;
    localparam int c_BW     = 128;
    localparam int c_VW     = c_N * c_W;
    localparam int c_ENG_LAT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              job_done;
    logic              sort_start;
    logic              sort_done = 1'b0;
    logic [c_VW-1:0]   sort_result = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [c_BW-1:0]   m_data;
    logic              m_last;

    int n_checks = 0;
    int n_fail   = 0;

    sort_stream_out #(
        .TOTAL_NUM (c_N),
        .WORD_W    (c_W),
        .BEAT_W    (c_BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .job_done    (job_done),
        .sort_start  (sort_start),
        .sort_done   (sort_done),
        .sort_result (sort_result),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural sort engine ----------------
    logic [31:0] in_words [c_N];
    logic [31:0] eng_words [c_N];
    int          eng_timer = 0;
    bit          eng_run = 1'b0;
    bit          eng_drop = 1'b0;
    bit          eng_keep_stale = 1'b0;
    int          perm [c_N] = '{7, 12, 3, 0, 15, 9, 1, 10, 5, 14, 2, 8, 13, 4, 11, 6};

    function automatic logic [c_VW-1:0] sort_vec(input logic [31:0] w [c_N]);
        logic [31:0]     a [c_N];
        logic [31:0]     t;
        logic [c_VW-1:0] v;
        a = w;
        for (int i = 0; i < c_N - 1; i++)
            for (int j = 0; j < c_N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        v = '0;
        for (int i = 0; i < c_N; i++) v[i*c_W +: c_W] = a[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (sort_start) begin
            eng_timer <= c_ENG_LAT;
            eng_run   <= 1'b1;
            for (int i = 0; i < c_N; i++) eng_words[i] <= in_words[i];
            if (eng_keep_stale) eng_drop <= 1'b1;
            else                sort_done <= 1'b0;
        end else begin
            if (eng_drop) begin
                sort_done <= 1'b0;
                eng_drop  <= 1'b0;
            end
            if (eng_run) begin
                if (eng_timer == 0) begin
                    sort_done   <= 1'b1;
                    sort_result <= sort_vec(eng_words);
                    eng_run     <= 1'b0;
                end else begin
                    eng_timer <= eng_timer - 1;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [c_BW-1:0] cap_data [$];
    logic            cap_last [$];
    int cyc = 0, n_kick = 0, n_done = 0, stall_err = 0, idle_cyc = 0;
    int last_hs_cyc = 0, done_cyc = 0, valid_rise_cyc = 0, done_rise_cyc = 0;
    bit prev_stall = 0, prev_valid = 0, prev_done = 0, prev_last = 0;
    logic [c_BW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            prev_valid = 0;
        end else begin
            if (m_valid && m_ready) begin
                cap_data.push_back(m_data);
                cap_last.push_back(m_last);
                last_hs_cyc = cyc;
            end
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stall_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = m_valid;
            if (sort_done && !prev_done) done_rise_cyc = cyc;
            if (sort_start) n_kick++;
            if (job_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy) idle_cyc++;
        end
        prev_done = sort_done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [31:0] bv, input logic [31:0] st);
        for (int i = 0; i < c_N; i++) in_words[i] = bv + 32'(perm[i]) * st;
    endtask

    // Sorted word i of a job is bv + i*st, so beat k holds words 4k..4k+3
    function automatic logic [c_BW-1:0] exp_beat(input logic [31:0] bv, input logic [31:0] st, input int k);
        logic [c_BW-1:0] b;
        for (int j = 0; j < 4; j++) b[j*32 +: 32] = bv + 32'(4*k + j) * st;
        return b;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit timed_out);
        int t = 0;
        while (n_done < target && t < budget) begin
            tick();
            t++;
        end
        timed_out = (n_done < target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_last !== 1'b0)     begin n_fail++; $display("FAIL reset_last: got %b expected 0", m_last); end
        n_checks++; if (m_data !== '0)       begin n_fail++; $display("FAIL reset_data: got %h expected 0", m_data); end
        n_checks++; if (sort_start !== 1'b0) begin n_fail++; $display("FAIL reset_kick: got %b expected 0", sort_start); end
        n_checks++; if (job_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", job_done); end
        start = 1'b0; m_ready = 1'b0; rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int k0 = n_kick, d0 = n_done, base = cap_data.size();
        bit to;
        set_job(32'h0000_1000, 32'd3);
        m_ready = 1'b1;
        pulse_start();
        wait_done(d0 + 1, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no job_done expected one"); end
        n_checks++; if (n_kick - k0 !== 1) begin n_fail++; $display("FAIL basic_kicks: got %0d expected 1", n_kick - k0); end
        n_checks++; if (cap_data.size() - base !== 4) begin n_fail++; $display("FAIL basic_beats: got %0d expected 4", cap_data.size() - base); end
        for (int k = 0; k < 4 && base + k < cap_data.size(); k++) begin
            n_checks++;
            if (cap_data[base+k] !== exp_beat(32'h0000_1000, 32'd3, k)) begin
                n_fail++; $display("FAIL basic_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(32'h0000_1000, 32'd3, k));
            end
            n_checks++;
            if (cap_last[base+k] !== (k == 3)) begin
                n_fail++; $display("FAIL basic_last%0d: got %b expected %b", k, cap_last[base+k], (k == 3));
            end
        end
        n_checks++; if (valid_rise_cyc !== done_rise_cyc + 1) begin n_fail++; $display("FAIL basic_latency: valid at %0d expected %0d", valid_rise_cyc, done_rise_cyc + 1); end
        n_checks++; if (done_cyc !== last_hs_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit pat [16] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1};
        int d0 = n_done, base = cap_data.size(), s0 = stall_err, t = 0;
        set_job(32'h2000_0000, 32'h111);
        pulse_start();
        while (n_done < d0 + 1 && t < 300) begin
            m_ready = pat[t % 16];
            tick();
            t++;
        end
        m_ready = 1'b0;
        n_checks++; if (n_done < d0 + 1) begin n_fail++; $display("FAIL bp_timeout: got no job_done expected one"); end
        n_checks++; if (stall_err - s0 !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err - s0); end
        n_checks++; if (cap_data.size() - base !== 4) begin n_fail++; $display("FAIL bp_beats: got %0d expected 4", cap_data.size() - base); end
        for (int k = 0; k < 4 && base + k < cap_data.size(); k++) begin
            n_checks++;
            if (cap_data[base+k] !== exp_beat(32'h2000_0000, 32'h111, k)) begin
                n_fail++; $display("FAIL bp_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(32'h2000_0000, 32'h111, k));
            end
            n_checks++;
            if (cap_last[base+k] !== (k == 3)) begin
                n_fail++; $display("FAIL bp_last%0d: got %b expected %b", k, cap_last[base+k], (k == 3));
            end
        end
    endtask

    task automatic test_stale_done();
        int d0 = n_done, base = cap_data.size();
        bit to;
        eng_keep_stale = 1'b1;
        set_job(32'h0000_3300, 32'd7);
        m_ready = 1'b1;
        pulse_start();
        wait_done(d0 + 1, 200, to);
        eng_keep_stale = 1'b0;
        n_checks++; if (to) begin n_fail++; $display("FAIL stale_timeout: got no job_done expected one"); end
        n_checks++; if (valid_rise_cyc !== done_rise_cyc + 1) begin n_fail++; $display("FAIL stale_early_valid: valid at %0d expected %0d", valid_rise_cyc, done_rise_cyc + 1); end
        n_checks++; if (cap_data.size() - base !== 4) begin n_fail++; $display("FAIL stale_beats: got %0d expected 4", cap_data.size() - base); end
        for (int k = 0; k < 4 && base + k < cap_data.size(); k++) begin
            n_checks++;
            if (cap_data[base+k] !== exp_beat(32'h0000_3300, 32'd7, k)) begin
                n_fail++; $display("FAIL stale_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(32'h0000_3300, 32'd7, k));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int d0, base = cap_data.size(), t = 0;
        bit to;
        set_job(32'h0000_0044, 32'h0001_0000);
        m_ready = 1'b0;
        pulse_start();
        while (!m_valid && t < 100) begin tick(); t++; end
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_timeout: got %b expected 1", m_valid); end
        m_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1; m_ready = 1'b0;
        tick();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", m_valid); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (m_data !== '0)    begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", m_data); end
        n_checks++; if (m_last !== 1'b0)  begin n_fail++; $display("FAIL rstmid_last: got %b expected 0", m_last); end
        n_checks++; if (cap_data.size() - base !== 2) begin n_fail++; $display("FAIL rstmid_partial: got %0d expected 2", cap_data.size() - base); end
        rst = 1'b0;
        tick();
        d0 = n_done;
        base = cap_data.size();
        m_ready = 1'b1;
        pulse_start();
        wait_done(d0 + 1, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_restart_timeout: got no job_done expected one"); end
        n_checks++; if (cap_data.size() - base !== 4) begin n_fail++; $display("FAIL rstmid_restart_beats: got %0d expected 4", cap_data.size() - base); end
        for (int k = 0; k < 4 && base + k < cap_data.size(); k++) begin
            n_checks++;
            if (cap_data[base+k] !== exp_beat(32'h0000_0044, 32'h0001_0000, k)) begin
                n_fail++; $display("FAIL rstmid_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(32'h0000_0044, 32'h0001_0000, k));
            end
        end
    endtask

`ifndef SORT_STREAM_SHADOW_EN
    task automatic test_start_while_busy();
        int k0 = n_kick, d0 = n_done, base = cap_data.size(), t = 0;
        bit to;
        set_job(32'h0000_5000, 32'd1);
        m_ready = 1'b0;
        pulse_start();
        tick();
        pulse_start();
        while (!m_valid && t < 100) begin tick(); t++; end
        pulse_start();
        m_ready = 1'b1;
        wait_done(d0 + 1, 200, to);
        repeat (12) tick();
        n_checks++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: got no job_done expected one"); end
        n_checks++; if (n_kick - k0 !== 1) begin n_fail++; $display("FAIL busy_start_kicks: got %0d expected 1", n_kick - k0); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d expected 1", n_done - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
        n_checks++; if (cap_data.size() - base !== 4) begin n_fail++; $display("FAIL busy_start_beats: got %0d expected 4", cap_data.size() - base); end
        for (int k = 0; k < 4 && base + k < cap_data.size(); k++) begin
            n_checks++;
            if (cap_data[base+k] !== exp_beat(32'h0000_5000, 32'd1, k)) begin
                n_fail++; $display("FAIL busy_start_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(32'h0000_5000, 32'd1, k));
            end
        end
    endtask
`else
    task automatic test_start_while_busy();
        int k0 = n_kick, d0 = n_done, base = cap_data.size(), t = 0, i0;
        bit to;
        logic [31:0] bv, st;
        set_job(32'h0000_6000, 32'd2);
        m_ready = 1'b0;
        pulse_start();
        i0 = idle_cyc;
        while (!m_valid && t < 100) begin tick(); t++; end
        set_job(32'h0000_7000, 32'd5);
        pulse_start();
        m_ready = 1'b1;
        wait_done(d0 + 2, 300, to);
        m_ready = 1'b0;
        n_checks++; if (to) begin n_fail++; $display("FAIL shadow_timeout: got %0d job_done expected 2", n_done - d0); end
        n_checks++; if (n_kick - k0 !== 2) begin n_fail++; $display("FAIL shadow_kicks: got %0d expected 2", n_kick - k0); end
        n_checks++; if (idle_cyc - i0 !== 1) begin n_fail++; $display("FAIL shadow_idle_gap: got %0d idle cycles expected 1", idle_cyc - i0); end
        n_checks++; if (cap_data.size() - base !== 8) begin n_fail++; $display("FAIL shadow_beats: got %0d expected 8", cap_data.size() - base); end
        for (int k = 0; k < 8 && base + k < cap_data.size(); k++) begin
            bv = (k < 4) ? 32'h0000_6000 : 32'h0000_7000;
            st = (k < 4) ? 32'd2 : 32'd5;
            n_checks++;
            if (cap_data[base+k] !== exp_beat(bv, st, k % 4)) begin
                n_fail++; $display("FAIL shadow_data%0d: got %h expected %h", k, cap_data[base+k], exp_beat(bv, st, k % 4));
            end
            n_checks++;
            if (cap_last[base+k] !== (k % 4 == 3)) begin
                n_fail++; $display("FAIL shadow_last%0d: got %b expected %b", k, cap_last[base+k], (k % 4 == 3));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_done();
        test_reset_midstream();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
